// File: rtl/hcode_loopback_fifo.sv
// Loopback buffer between an upstream and a downstream ap_fifo port: words are queued in a
// DEPTH-entry circular buffer and returned through a run-time selectable transform.
module hcode_loopback_fifo #(
    parameter int DATA_W = 128,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = 32
) (
    input  logic                         ap_clk,
    input  logic                         ap_rst,
    input  logic [1:0]                   mode,
    input  logic [DATA_W-1:0]            in_V_V_dout,
    input  logic                         in_V_V_empty_n,
    output logic                         in_V_V_read,
    output logic [DATA_W-1:0]            out_V_V_din,
    input  logic                         out_V_V_full_n,
    output logic                         out_V_V_write,
    output logic [$clog2(DEPTH):0]       level,
    output logic [CNT_W-1:0]             in_cnt,
    output logic [CNT_W-1:0]             out_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int NB = DATA_W / 8;
    localparam logic [AW:0] LEVEL_FULL = (AW+1)'(DEPTH);

    localparam logic [1:0] MODE_PASS = 2'd0;
    localparam logic [1:0] MODE_REV  = 2'd1;
    localparam logic [1:0] MODE_INV  = 2'd2;
    localparam logic [1:0] MODE_INC  = 2'd3;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr_reg;
    logic [AW-1:0]     rd_ptr_reg;
    logic [AW:0]       level_reg;
    logic [CNT_W-1:0]  in_cnt_reg;
    logic [CNT_W-1:0]  out_cnt_reg;

    logic              push;
    logic              pop;
    logic [DATA_W-1:0] head;
    logic [DATA_W-1:0] head_rev;
    logic [DATA_W-1:0] din_next;

    // Full/empty come from level only, so a full cycle never accepts even while popping.
    assign push = !ap_rst && in_V_V_empty_n && (level_reg != LEVEL_FULL);
    assign pop  = !ap_rst && (level_reg != '0) && out_V_V_full_n;

    assign in_V_V_read   = push;
    assign out_V_V_write = pop;
    assign level         = level_reg;
    assign in_cnt        = in_cnt_reg;
    assign out_cnt       = out_cnt_reg;

    always_ff @(posedge ap_clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= in_V_V_dout;
        end
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            level_reg   <= '0;
            in_cnt_reg  <= '0;
            out_cnt_reg <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
                in_cnt_reg <= in_cnt_reg + CNT_W'(1);
            end
            if (pop) begin
                rd_ptr_reg  <= rd_ptr_reg + AW'(1);
                out_cnt_reg <= out_cnt_reg + CNT_W'(1);
            end
            case ({push, pop})
                2'b10:   level_reg <= level_reg + (AW+1)'(1);
                2'b01:   level_reg <= level_reg - (AW+1)'(1);
                default: level_reg <= level_reg;
            endcase
        end
    end

    // Transform is applied at emit time, so a mode change also affects buffered words.
    assign head = mem[rd_ptr_reg];

    generate
        for (genvar gi = 0; gi < NB; gi++) begin : g_byte_rev
            assign head_rev[gi*8 +: 8] = head[(NB-1-gi)*8 +: 8];
        end
    endgenerate

    always_comb begin
        din_next = head;
        case (mode)
            MODE_PASS: din_next = head;
            MODE_REV:  din_next = head_rev;
            MODE_INV:  din_next = ~head;
            MODE_INC:  din_next = head + DATA_W'(1);
            default:   din_next = head;
        endcase
    end

    assign out_V_V_din = din_next;

endmodule
